// File: rtl/alu_pkg.sv
// Constants shared by the ALU operand path: operand width and the
// operand-register state encodings.
package alu_pkg;
  localparam int   OPERAND_WIDTH = 4;
  localparam logic ST_EMPTY      = 1'b0;
  localparam logic ST_FULL       = 1'b1;

  typedef enum logic {
    EMPTY = ST_EMPTY,
    FULL  = ST_FULL
  } arb_state_t;
endpackage

// File: rtl/mux2to1.sv
// Generic two-input operand multiplexer; sel = 0 picks in0.
module mux2to1 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/operand_arbiter.sv
// Round-robin arbiter sharing the ALU operand path between two requesters,
// with a one-entry valid/ready output register.
//
// state | meaning
// EMPTY | output register holds nothing; any request is granted
// FULL  | output register holds an operand; grants only when it drains
module operand_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = OPERAND_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  arb_state_t       state, state_nxt;
  logic             last;
  logic             free;
  logic             gnt_any;
  logic             win;
  logic [WIDTH-1:0] mux_out;

  assign out_valid = (state == FULL);

  mux2to1 #(.WIDTH(WIDTH)) u_mux (
    .in0 (data0),
    .in1 (data1),
    .sel (sel),
    .out (mux_out)
  );

  // win defaults to last so the mux select only moves on a grant
  always_comb begin
    state_nxt = state;
    gnt_any   = 1'b0;
    win       = last;
    free      = !out_valid || out_ready;
    if (rst_n && free && (req0 || req1)) begin
      gnt_any = 1'b1;
      if (req0 && req1) win = ~last;
      else              win = req1;
    end
    case (state)
      EMPTY:   if (gnt_any) state_nxt = FULL;
      FULL:    if (out_ready && !gnt_any) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign sel  = win;
  assign gnt0 = gnt_any & ~win;
  assign gnt1 = gnt_any & win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // last resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      out_data <= '0;
      out_src  <= 1'b0;
    end else if (gnt_any) begin
      last     <= win;
      out_data <= mux_out;
      out_src  <= win;
    end
  end

endmodule

// File: tb/tb_operand_arbiter.sv
// Bench for operand_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level model.
module tb_operand_arbiter;
  import alu_pkg::*;
  localparam int W = OPERAND_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, out_ready = 1'b0;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic         gnt0, gnt1, sel, out_valid, out_src;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  operand_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: slot free when empty or draining; a tie goes to the requester that did not win last.
  function automatic int winner_of(logic rn, logic r0, logic r1, logic v, logic rdy, logic lst);
    if (!rn || (v && !rdy)) return -1;
    if (r0 && r1) return lst ? 0 : 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  logic         m_valid, m_src, m_last;
  logic [W-1:0] m_data;
  int           exp_winner = -1;
  int           cur_w;

  assign cur_w = winner_of(rst_n, req0, req1, m_valid, out_ready, m_last);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= 1'b0;
      m_last  <= 1'b1;
    end else if (exp_winner >= 0) begin
      m_valid <= 1'b1;
      m_data  <= (exp_winner == 1) ? data1 : data0;
      m_src   <= (exp_winner == 1);
      m_last  <= (exp_winner == 1);
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_winner <= cur_w;
    if (!rst_n) begin
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_out_valid", out_valid, 0);
    end else begin
      chk("gnt0", gnt0, cur_w == 0);
      chk("gnt1", gnt1, cur_w == 1);
      chk("sel", sel, (cur_w < 0) ? m_last : (cur_w == 1));
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("out_data", out_data, m_data);
        chk("out_src", out_src, m_src);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int w;
    // reset state
    #2;
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_src", out_src, 0);
    tick(); tick();
    rst_n = 1'b1;

    // contention alternation, first tie to requester 0
    req0 = 1; req1 = 1; data0 = 4'h3; data1 = 4'hC; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("alt_gnt0", gnt0, (i % 2) == 0);
      chk("alt_gnt1", gnt1, (i % 2) == 1);
      tick();
      chk("alt_data", out_data, (i % 2) ? 4'hC : 4'h3);
      chk("alt_valid", out_valid, 1);
    end

    // drain to empty; sel parks on last winner (requester 1)
    req0 = 0; req1 = 0;
    #1;
    chk("drain_sel", sel, 1);
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_sel_idle", sel, 1);

    // single requester
    req0 = 1; data0 = 4'h5;
    #1;
    chk("single_gnt0", gnt0, 1);
    tick();
    req0 = 0;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 4'h5);
    chk("single_src", out_src, 0);

    // backpressure holding 7
    req0 = 1; data0 = 4'h7;
    tick();
    req0 = 0; out_ready = 0; req1 = 1; data1 = 4'h9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_gnt1", gnt1, 0);
      chk("bp_data", out_data, 4'h7);
      tick();
    end
    out_ready = 1;
    #1;
    chk("bp_release_gnt1", gnt1, 1);
    tick();
    req1 = 0;
    chk("bp_valid", out_valid, 1);
    chk("bp_new_data", out_data, 4'h9);
    chk("bp_new_src", out_src, 1);

    // withdraw while stalled: last stays at requester 0
    req0 = 1; data0 = 4'h4;
    #1;
    chk("wd_pre_gnt0", gnt0, 1);
    tick();
    req0 = 0; out_ready = 0; req1 = 1; data1 = 4'h2;
    #1;
    chk("wd_gnt1", gnt1, 0);
    chk("wd_sel", sel, 0);
    tick();
    req1 = 0;
    tick();
    out_ready = 1; req0 = 1; req1 = 1; data0 = 4'h6; data1 = 4'h8;
    #1;
    chk("wd_last_gnt1", gnt1, 1);
    tick();

    // async reset while FULL holding A
    req1 = 0; req0 = 1; data0 = 4'hA; out_ready = 1;
    #1;
    chk("ld_gnt0", gnt0, 1);
    tick();
    out_ready = 0;
    #1;
    chk("ld_data", out_data, 4'hA);
    #1;
    rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_gnt0", gnt0, 0);
    chk("arst_gnt1", gnt1, 0);
    tick();
    rst_n = 1; req1 = 1; out_ready = 1;
    #1;
    chk("post_rst_gnt0", gnt0, 1);
    chk("post_rst_gnt1", gnt1, 0);

    // randomized traffic obeying the requester hold rules
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      w = exp_winner;
      tick();
      if (!(req0 && w != 0 && $urandom_range(7) != 0)) begin
        req0 = $urandom_range(1);
        data0 = W'($urandom);
      end
      if (!(req1 && w != 1 && $urandom_range(7) != 0)) begin
        req1 = $urandom_range(1);
        data1 = W'($urandom);
      end
      out_ready = ($urandom_range(3) != 0);
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
